fir_filter_param: RTL and testbench

Parametrised successor to the fixed 25-tap 8-bit FIR. It is a signed, pipelined direct-form FIR with generic data and coefficient widths and tap count. Samples enter through a valid/ready handshake and results leave with out_valid. Coefficients load serially over a shift chain, with a loaded-count status. The block sits between the sample source and the downstream decimator/sink in the fir datapath.

---
 rtl/fir_filter_param.sv | 131 +++++++++++++
 tb/tb_fir_filter_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// fir_filter_param: signed, pipelined direct-form FIR with generic widths and tap count.
// Samples enter on a valid/ready handshake; coefficients load serially over a shift chain.
// Result latency is three cycles after the accept edge at one sample per cycle.
// Optional build macro FIR_ROUND_EN: round half up before the output shift
// (default build truncates toward minus infinity).
// Assumes OW <= AW+1 so the saturation bounds fit the widened accumulator.
module fir_filter_param #(
    parameter int TAPS      = 25,
    parameter int DW        = 8,
    parameter int CW        = 8,
    parameter int OW        = 8,
    parameter int OUT_SHIFT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_c,
    input  logic [CW-1:0] coef_in,
    output logic          coef_ready,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] data_in,
    output logic          out_valid,
    output logic [OW-1:0] data_out
);

    localparam int AW   = DW + CW + $clog2(TAPS);
    localparam int PW   = DW + CW;
    localparam int XW   = AW + 1;
    localparam int CNTW = $clog2(TAPS + 1);

    // Clamp bounds expressed in the widened accumulator width.
    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [CW-1:0] coef [TAPS];
    logic signed [DW-1:0] smp  [TAPS];
    logic signed [PW-1:0] prod [TAPS];
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic signed [XW-1:0] acc_ext;
    logic signed [XW-1:0] shifted;
    logic [OW-1:0]        sat_val;
    logic [CNTW-1:0]      coef_cnt;
    logic                 accept;
    logic                 v0;
    logic                 v1;
    logic                 v2;

    // A coefficient load owns the cycle; the source must hold its sample.
    assign in_ready   = ~load_c;
    assign accept     = in_valid & ~load_c;
    assign coef_ready = (coef_cnt == CNTW'(TAPS));

    // Coefficient shift chain and saturating loaded-word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the tap arrays are reset on purpose so filtering before a full
            // load sees zero taps; a plain data RAM would normally skip this.
            for (int k = 0; k < TAPS; k++) coef[k] <= '0;
            coef_cnt <= '0;
        end else if (load_c) begin
            // NOTE: non-blocking assignments let every stage read the pre-edge
            // value of its neighbour, which is what makes this a shift chain.
            coef[0] <= $signed(coef_in);
            for (int k = 1; k < TAPS; k++) coef[k] <= coef[k-1];
            if (!coef_ready) coef_cnt <= coef_cnt + 1'b1;
        end
    end

    // Sample delay line; shifts only on an accepted sample, and launches its valid bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) smp[k] <= '0;
            v0 <= 1'b0;
        end else begin
            v0 <= accept;
            if (accept) begin
                smp[0] <= $signed(data_in);
                for (int k = 1; k < TAPS; k++) smp[k] <= smp[k-1];
            end
        end
    end

    // Adder tree input: sign-extend every product into the accumulator width.
    always_comb begin
        // NOTE: the default assignment up front keeps this purely combinational.
        sum = '0;
        for (int k = 0; k < TAPS; k++) sum = sum + AW'(prod[k]);
    end

`ifdef FIR_ROUND_EN
    localparam int                RSH      = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [XW-1:0] RND_BIAS = (OUT_SHIFT > 0) ? (XW'(1) << RSH) : '0;
    assign acc_ext = {acc[AW-1], acc} + RND_BIAS;
`else
    assign acc_ext = {acc[AW-1], acc};
`endif

    assign shifted = acc_ext >>> OUT_SHIFT;

    // Clamp the shifted accumulator into the signed output range.
    always_comb begin
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[OW-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[OW-1:0];
        end else begin
            sat_val = shifted[OW-1:0];
        end
    end

    // Multiply, accumulate and output stages; only the valid bit gates the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) prod[k] <= '0;
            acc       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) prod[k] <= PW'(smp[k]) * PW'(coef[k]);
            v1        <= v0;
            acc       <= sum;
            v2        <= v1;
            out_valid <= v2;
            if (v2) data_out <= sat_val;
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: a default-width instance (a) and a 16-bit, unshifted
// instance (b) share every input. Stimulus pushes hand-computed results for both
// into a scoreboard; a monitor pops them whenever the outputs are valid.
module tb_fir_filter_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_c;
    logic [7:0]  coef_in;
    logic        in_valid;
    logic [7:0]  data_in;

    logic        coef_ready_a, in_ready_a, out_valid_a;
    logic [7:0]  data_out_a;
    logic        coef_ready_b, in_ready_b, out_valid_b;
    logic [15:0] data_out_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int va;
        int vb;
        int due;
        bit care;
    } exp_t;

    exp_t q[$];

`ifdef FIR_ROUND_EN
    localparam int A_NEG13 = -69;
    localparam int A_P254  = 1;
    localparam int A_M2    = 0;
`else
    localparam int A_NEG13 = -70;
    localparam int A_P254  = 0;
    localparam int A_M2    = -1;
`endif

    fir_filter_param dut_a (
        .clk(clk), .reset(reset), .load_c(load_c), .coef_in(coef_in),
        .coef_ready(coef_ready_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .data_in(data_in), .out_valid(out_valid_a), .data_out(data_out_a)
    );

    fir_filter_param #(.OW(16), .OUT_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .load_c(load_c), .coef_in(coef_in),
        .coef_ready(coef_ready_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .data_in(data_in), .out_valid(out_valid_b), .data_out(data_out_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int va, input int vb, input bit care);
        exp_t e;
        e.va   = va;
        e.vb   = vb;
        e.due  = cyc + 4;
        e.care = care;
        q.push_back(e);
    endtask

    task automatic send(input logic signed [7:0] x, input int va, input int vb);
        @(negedge clk);
        load_c   = 1'b0;
        in_valid = 1'b1;
        data_in  = x;
        push(va, vb, 1'b1);
    endtask

    task automatic idle();
        @(negedge clk);
        load_c   = 1'b0;
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: flags overdue, spurious, late/early and wrong results.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            check("missing_out_valid", 0, 1);
        end
        if (out_valid_a === 1'b1 || out_valid_b === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_out_valid_a", out_valid_a, 0);
                check("spurious_out_valid_b", out_valid_b, 0);
            end else begin
                e = q.pop_front();
                check("latency", cyc, e.due);
                check("out_valid_a", out_valid_a, 1);
                check("out_valid_b", out_valid_b, 1);
                if (e.care) begin
                    check("data_out_a", $signed(data_out_a), e.va);
                    check("data_out_b", $signed(data_out_b), e.vb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        load_c   = 1'b0;
        coef_in  = '0;
        in_valid = 1'b0;
        data_in  = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_data_out_a", data_out_a, 0);
        check("rst_data_out_b", data_out_b, 0);
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_coef_ready_a", coef_ready_a, 0);
        check("rst_in_ready_a", in_ready_a, 1);
        reset = 1'b0;

        // Load and sample together: load wins, sample is not consumed.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_c   = 1'b1;
            coef_in  = 8'(25 - i);
            in_valid = 1'b1;
            data_in  = 8'd55;
            #1;
            check("hs_in_ready_a", in_ready_a, 0);
            check("hs_in_ready_b", in_ready_b, 0);
        end
        // Remaining loads of 25..1; coef_ready must rise exactly on the 25th.
        for (int i = 3; i < 25; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (i == 24) check("cnt24_coef_ready", coef_ready_a, 0);
            load_c  = 1'b1;
            coef_in = 8'(25 - i);
        end
        @(negedge clk);
        load_c = 1'b0;
        check("cnt25_coef_ready_a", coef_ready_a, 1);
        check("cnt25_coef_ready_b", coef_ready_b, 1);

        // Impulse: b shows 1..25 then 0; a shifts every tap sum below one LSB.
        send(8'sd1, 0, 1);
        for (int k = 2; k <= 25; k++) begin
            send(8'sd0, 0, k);
            if (k == 12) idle();
        end
        send(8'sd0, 0, 0);
        idle();

        // All coefficients 127; the first of these is the 26th load.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (i == 1) check("load26_coef_ready", coef_ready_a, 1);
            load_c  = 1'b1;
            coef_in = 8'd127;
        end

        // Positive saturation: acc = 16129*k, 403225 at full history.
        send(8'sd127, 63, 16129);
        send(8'sd127, 126, 32258);
        for (int k = 3; k <= 25; k++) send(8'sd127, 127, 32767);

        // Negative: acc = 127*(3175-255k), reaching -406400.
        for (int k = 1; k <= 11; k++) send(-8'sd128, 127, 32767);
        send(-8'sd128, 57, 14605);
        send(-8'sd128, A_NEG13, -17780);
        for (int k = 14; k <= 25; k++) send(-8'sd128, -128, -32768);
        idle();

        // coef[0]=2, all others 0: rounding and floor behaviour at one LSB.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            load_c   = 1'b1;
            coef_in  = (i == 24) ? 8'd2 : 8'd0;
        end
        send(8'sd127, A_P254, 254);
        send(-8'sd1, A_M2, -2);
        send(8'sd0, 0, 0);
        idle();
        repeat (4) idle();

        // Reset mid-stream: first result emerges, then reset lands between edges.
        send(-8'sd128, -1, -256);
        send(-8'sd128, -1, -256);
        send(-8'sd128, -1, -256);
        idle();
        @(negedge clk);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check("mid_rst_data_out_a", data_out_a, 0);
        check("mid_rst_data_out_b", data_out_b, 0);
        check("mid_rst_out_valid_a", out_valid_a, 0);
        check("mid_rst_out_valid_b", out_valid_b, 0);
        check("mid_rst_coef_ready_a", coef_ready_a, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) idle();
        check("post_rst_coef_ready_b", coef_ready_b, 0);
        // Fresh sample after reset: taps are cleared so the result is 0.
        send(8'sd5, 0, 0);
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
